runner_motion: RTL
==================

# runner_motion

Consumes the 3-bit movement codes produced by the keyboard input decoder (001 big jump, 010 small jump, 011 crouch, 100 drop) and turns them into the runner's vertical trajectory and pose. Sits between the input decoder and the renderer/collision logic. Outputs are a height above ground, a crouch flag, an airborne flag and a one-cycle landing pulse. Commands are sampled every clock; position advances only on the frame `tick` enable.

## Interface
- `BIG_H`, 64: apex height for a big jump (001).
- `SMALL_H`, 32: apex height for a small jump (010).
- `STEP`, 4: rise/fall distance per tick.
- `DROP_STEP`, 16: fall distance per tick after a drop (100).
- `HANG_TICKS`, 4: ticks spent at apex (only with `RUNNER_MOTION_HANG_EN`).
- Legal ranges: 1 ≤ `STEP`, `DROP_STEP` ≤ 64; `SMALL_H`, `BIG_H` ≤ 255; 1 ≤ `HANG_TICKS` ≤ 255.

- `clk` input 1: single system clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `movement` input 3: command code from the input decoder. Jump and drop codes are 1-cycle pulses. Crouch (011) is held for as long as the key is held.
- `tick` input 1: frame-rate enable, 1 clk wide.
- `y_pos` output 8: height above ground, 0 = on ground.
- `crouching` output 1: runner in crouch pose.
- `airborne` output 1: high in RISE, HANG, FALL, DROP.
- `landed` output 1: 1-clk pulse on the cycle y_pos returns to 0.

## Operation
States: GROUND, CROUCH, RISE, HANG, FALL, DROP. Registers: `y_pos`, `target` (8b), `hang_cnt` (8b).

- **GROUND**
  - 001 → RISE, target=BIG_H.
  - 010 → RISE, target=SMALL_H.
  - 011 → CROUCH.
  - 100 and 101–111 are ignored.
- **CROUCH**
  - `crouching`=1.
  - Stays in CROUCH while `movement`==011.
  - Any other value → GROUND. The code that caused the exit is discarded.
- **RISE**, on tick:
  - If y_pos+STEP ≥ target (9-bit compare): y_pos=target and go to HANG, with hang_cnt=0.
  - Otherwise: y_pos += STEP.
- **HANG**, on tick:
  - hang_cnt increments.
  - When hang_cnt reaches HANG_TICKS−1 on a tick, go to FALL.
  - y_pos is held.
- **FALL / DROP**, on tick:
  - Fall distance d = STEP in FALL, DROP_STEP in DROP.
  - If y_pos ≤ d: y_pos=0, go to GROUND, assert `landed` for that clk.
  - Otherwise: y_pos −= d.
  - No wrap-around below 0.
- **Drop:** code 100 in RISE, HANG or FALL → DROP immediately, from the current y_pos.
- **Ignored while airborne:** jump and crouch codes in RISE, HANG, FALL or DROP. A second drop in DROP is also ignored.
- **Landing reuse:** a jump code arriving on the same clk as the landing transition is ignored, because the state is still FALL/DROP on that edge.

## Timing
- Reset values: y_pos=0, crouching=0, airborne=0, landed=0, state=GROUND, target=0, hang_cnt=0. Reset is effective mid-flight; there is no resume.
- All outputs are registered. `crouching` and `airborne` reflect the registered state.
- Command and tick on the same clk: the state transition wins and y_pos is unchanged that clk. Example: a jump with tick in GROUND gives the first rise on the next tick.
- Command → state change: 1 clk, independent of tick.
- Big jump flight time (defaults, hang on): 16 rise ticks + 4 hang ticks + 16 fall ticks.
- `landed` is coincident with y_pos becoming 0 and lasts exactly 1 clk.

## Configuration
- `RUNNER_MOTION_HANG_EN`
  - Defined: HANG state and `hang_cnt` are present, as described above.
  - Undefined: HANG and `hang_cnt` are compiled out, and RISE goes directly to FALL on the tick that reaches target. A drop during RISE or FALL behaves identically in both builds.

## Test plan
- **Reset/idle:** reset low mid-RISE at y_pos=20 → all outputs 0 and GROUND next clk. Then ticks with movement=000 → y_pos stays 0.
- **Big jump:** 001 pulse, then ticks → y_pos 4,8,…,64; hold for 4 ticks (HANG_EN); then 60,…,0; `landed` high 1 clk. Repeat with the macro undefined → no hold at 64.
- **Small jump + drop:** 010, 5 rise ticks (y_pos=20), 100 pulse → DROP; next ticks → y_pos 4 then 0; landed pulse.
- **Crouch:** movement=011 for 10 clks → crouching=1 from clk 1 to clk 10. Then 000 → crouching=0 the next clk. A 001 arriving on the exit clk → no jump.
- **Ignored commands:** 001/010/011 during RISE, and 100 and 101–111 in GROUND → no state or y_pos change.
- **Simultaneity:** 001 and tick on the same clk → y_pos=0 that clk and 4 on the next tick. A jump pulse on the landing clk → remains in GROUND.

Source files
------------

// File: rtl/runner_motion.sv
// Vertical motion controller for the runner: turns decoder movement codes into height, pose and landing pulse.
// Optional apex hold is enabled by defining RUNNER_MOTION_HANG_EN.
module runner_motion #(
  parameter int BIG_H      = 64,
  parameter int SMALL_H    = 32,
  parameter int STEP       = 4,
  parameter int DROP_STEP  = 16,
  parameter int HANG_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] movement,
  input  logic       tick,
  output logic [7:0] y_pos,
  output logic       crouching,
  output logic       airborne,
  output logic       landed
);

  localparam logic [2:0] MV_BIG    = 3'b001;
  localparam logic [2:0] MV_SMALL  = 3'b010;
  localparam logic [2:0] MV_CROUCH = 3'b011;
  localparam logic [2:0] MV_DROP   = 3'b100;

  localparam logic [7:0] BIG_H8  = 8'(BIG_H);
  localparam logic [7:0] SMALL_H8 = 8'(SMALL_H);
  localparam logic [7:0] STEP8   = 8'(STEP);
  localparam logic [7:0] DROP8   = 8'(DROP_STEP);

  if (STEP < 1 || STEP > 64 || DROP_STEP < 1 || DROP_STEP > 64 ||
      BIG_H > 255 || SMALL_H > 255 || HANG_TICKS < 1 || HANG_TICKS > 255) begin : g_param_chk
    $error("runner_motion: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_GROUND,
    S_CROUCH,
    S_RISE,
    S_FALL,
    S_DROP
`ifdef RUNNER_MOTION_HANG_EN
    , S_HANG
`endif
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] target, target_nxt;
  logic [7:0] y_nxt;
  logic       landed_nxt, crouch_nxt, air_nxt;
  logic [8:0] rise_sum;
  logic [7:0] fall_d;

`ifdef RUNNER_MOTION_HANG_EN
  localparam logic [7:0] HANG_LAST = 8'(HANG_TICKS - 1);
  logic [7:0] hang_cnt, hang_nxt;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_GROUND;
      target    <= '0;
      y_pos     <= '0;
      landed    <= 1'b0;
      crouching <= 1'b0;
      airborne  <= 1'b0;
`ifdef RUNNER_MOTION_HANG_EN
      hang_cnt  <= '0;
`endif
    end else begin
      state     <= state_nxt;
      target    <= target_nxt;
      y_pos     <= y_nxt;
      landed    <= landed_nxt;
      crouching <= crouch_nxt;
      airborne  <= air_nxt;
`ifdef RUNNER_MOTION_HANG_EN
      hang_cnt  <= hang_nxt;
`endif
    end
  end

  // Next state: a command transition always pre-empts the tick motion in the same clk
  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    y_nxt      = y_pos;
    landed_nxt = 1'b0;
`ifdef RUNNER_MOTION_HANG_EN
    hang_nxt   = hang_cnt;
`endif
    rise_sum = {1'b0, y_pos} + {1'b0, STEP8};
    fall_d   = (state == S_DROP) ? DROP8 : STEP8;
    case (state)
      S_GROUND: begin
        case (movement)
          MV_BIG:    begin state_nxt = S_RISE; target_nxt = BIG_H8;   end
          MV_SMALL:  begin state_nxt = S_RISE; target_nxt = SMALL_H8; end
          MV_CROUCH: state_nxt = S_CROUCH;
          default:   ;
        endcase
      end
      S_CROUCH: if (movement != MV_CROUCH) state_nxt = S_GROUND;
      S_RISE: begin
        if (movement == MV_DROP) state_nxt = S_DROP;
        else if (tick) begin
          if (rise_sum >= {1'b0, target}) begin
            y_nxt = target;
`ifdef RUNNER_MOTION_HANG_EN
            state_nxt = S_HANG;
            hang_nxt  = '0;
`else
            state_nxt = S_FALL;
`endif
          end else begin
            y_nxt = rise_sum[7:0];
          end
        end
      end
`ifdef RUNNER_MOTION_HANG_EN
      S_HANG: begin
        if (movement == MV_DROP) state_nxt = S_DROP;
        else if (tick) begin
          hang_nxt = hang_cnt + 8'd1;
          if (hang_cnt == HANG_LAST) state_nxt = S_FALL;
        end
      end
`endif
      S_FALL, S_DROP: begin
        if (state == S_FALL && movement == MV_DROP) state_nxt = S_DROP;
        else if (tick) begin
          if (y_pos <= fall_d) begin
            y_nxt      = '0;
            state_nxt  = S_GROUND;
            landed_nxt = 1'b1;
          end else begin
            y_nxt = y_pos - fall_d;
          end
        end
      end
      default: state_nxt = S_GROUND;
    endcase
  end

  // Pose flags are registered copies of the next state decode
  always_comb begin
    crouch_nxt = (state_nxt == S_CROUCH);
    air_nxt    = (state_nxt != S_GROUND) && (state_nxt != S_CROUCH);
  end

endmodule
